// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: opcode constants, immediate formats,
// field types and a combinational decode function usable at any XLEN.
package rv;

    typedef logic [31:0] inst_t;
    typedef logic [6:0]  opcode_t;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [2:0]  funct3_t;
    typedef logic [4:0]  funct5_t;
    typedef logic [6:0]  funct7_t;
    typedef logic [11:0] funct12_t;
    typedef logic [31:0] imm32_t;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_R4 = 3'd6
    } imm_fmt_e;

    localparam opcode_t OPC_LOAD      = 7'b0000011;
    localparam opcode_t OPC_LOAD_FP   = 7'b0000111;
    localparam opcode_t OPC_MISC_MEM  = 7'b0001111;
    localparam opcode_t OPC_OP_IMM    = 7'b0010011;
    localparam opcode_t OPC_AUIPC     = 7'b0010111;
    localparam opcode_t OPC_OP_IMM_32 = 7'b0011011;
    localparam opcode_t OPC_STORE     = 7'b0100011;
    localparam opcode_t OPC_STORE_FP  = 7'b0100111;
    localparam opcode_t OPC_AMO       = 7'b0101111;
    localparam opcode_t OPC_OP        = 7'b0110011;
    localparam opcode_t OPC_LUI       = 7'b0110111;
    localparam opcode_t OPC_OP_32     = 7'b0111011;
    localparam opcode_t OPC_MADD      = 7'b1000011;
    localparam opcode_t OPC_MSUB      = 7'b1000111;
    localparam opcode_t OPC_NMSUB     = 7'b1001011;
    localparam opcode_t OPC_NMADD     = 7'b1001111;
    localparam opcode_t OPC_OP_FP     = 7'b1010011;
    localparam opcode_t OPC_BRANCH    = 7'b1100011;
    localparam opcode_t OPC_JALR      = 7'b1100111;
    localparam opcode_t OPC_JAL       = 7'b1101111;
    localparam opcode_t OPC_SYSTEM    = 7'b1110011;

    // Immediate is kept at 32 bits sign-extended from inst[31]; the caller widens it to XLEN.
    typedef struct packed {
        opcode_t   opcode;
        reg_addr_t rd;
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rs3;
        funct3_t   funct3;
        funct5_t   funct5;
        funct7_t   funct7;
        funct12_t  funct12;
        imm32_t    imm;
        imm_fmt_e  fmt;
        logic      error;
    } decode_t;

    function automatic decode_t rv_decode(input inst_t inst, input int unsigned xlen,
                                          input bit enable_fp);
        decode_t d;
        logic    legal;
        logic    fp_op;
        logic    rv64_op;
        d       = '0;
        legal   = 1'b1;
        fp_op   = 1'b0;
        rv64_op = 1'b0;
        d.opcode  = inst[6:0];
        d.rd      = inst[11:7];
        d.rs1     = inst[19:15];
        d.rs2     = inst[24:20];
        d.rs3     = inst[31:27];
        d.funct3  = inst[14:12];
        d.funct5  = inst[31:27];
        d.funct7  = inst[31:25];
        d.funct12 = inst[31:20];
        case (d.opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: d.fmt = FMT_I;
            OPC_OP_IMM_32: begin d.fmt = FMT_I; rv64_op = 1'b1; end
            OPC_LOAD_FP:   begin d.fmt = FMT_I; fp_op = 1'b1; end
            OPC_STORE:     d.fmt = FMT_S;
            OPC_STORE_FP:  begin d.fmt = FMT_S; fp_op = 1'b1; end
            OPC_BRANCH:    d.fmt = FMT_B;
            OPC_LUI, OPC_AUIPC: d.fmt = FMT_U;
            OPC_JAL:       d.fmt = FMT_J;
            OPC_OP, OPC_AMO: d.fmt = FMT_R;
            OPC_OP_32:     begin d.fmt = FMT_R; rv64_op = 1'b1; end
            OPC_OP_FP:     begin d.fmt = FMT_R; fp_op = 1'b1; end
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin d.fmt = FMT_R4; fp_op = 1'b1; end
            default:       begin d.fmt = FMT_R; legal = 1'b0; end
        endcase
        case (d.fmt)
            FMT_I:   d.imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   d.imm = {inst[31:12], 12'b0};
            FMT_J:   d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        // funct3 001/101 are the shifts; shamt[5] only exists on RV64
        d.error = (inst[1:0] != 2'b11) || !legal || (rv64_op && xlen == 32) ||
                  (fp_op && !enable_fp) ||
                  (d.opcode == OPC_OP_IMM && d.funct3[1:0] == 2'b01 && xlen == 32 && inst[25]);
        return d;
    endfunction

endpackage

// File: rtl/rv_skid_buffer.sv
// Main register plus one skid entry: full throughput with in_ready taken
// straight from registered state.
module rv_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         run_q;
    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_fire;
    logic         drain;

    // run_q keeps in_ready low until the first edge after reset release
    assign in_ready  = run_q && !skid_valid && !flush;
    assign in_fire   = in_valid && in_ready;
    assign drain     = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            run_q <= 1'b1;
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!main_valid || drain) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= in_fire;
                    if (in_fire) main_q <= in_data;
                end
            end else if (in_fire) begin
                skid_q     <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Decode stage: combinational field/immediate decode of the incoming word,
// registered through a skid buffer with valid/ready on both sides.
module rv_decode_stage
    import rv::*;
#(
    parameter int XLEN      = 32,
    parameter bit ENABLE_FP = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rs3,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_funct5,
    output logic [6:0]      out_funct7,
    output logic [11:0]     out_funct12,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_fmt,
    output logic            out_decode_error
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("rv_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        inst_t           inst;
        logic [XLEN-1:0] pc;
        opcode_t         opcode;
        reg_addr_t       rd;
        reg_addr_t       rs1;
        reg_addr_t       rs2;
        reg_addr_t       rs3;
        funct3_t         funct3;
        funct5_t         funct5;
        funct7_t         funct7;
        funct12_t        funct12;
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            error;
    } payload_t;

    decode_t  dec;
    payload_t in_pl;
    payload_t out_pl;

    always_comb begin
        dec           = rv_decode(in_inst, XLEN, ENABLE_FP);
        in_pl.inst    = in_inst;
        in_pl.pc      = in_pc;
        in_pl.opcode  = dec.opcode;
        in_pl.rd      = dec.rd;
        in_pl.rs1     = dec.rs1;
        in_pl.rs2     = dec.rs2;
        in_pl.rs3     = dec.rs3;
        in_pl.funct3  = dec.funct3;
        in_pl.funct5  = dec.funct5;
        in_pl.funct7  = dec.funct7;
        in_pl.funct12 = dec.funct12;
        in_pl.imm     = XLEN'($signed(dec.imm));
        in_pl.fmt     = dec.fmt;
        in_pl.error   = dec.error;
    end

    rv_skid_buffer #(.W($bits(payload_t))) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

    assign out_inst         = out_pl.inst;
    assign out_pc           = out_pl.pc;
    assign out_opcode       = out_pl.opcode;
    assign out_rd           = out_pl.rd;
    assign out_rs1          = out_pl.rs1;
    assign out_rs2          = out_pl.rs2;
    assign out_rs3          = out_pl.rs3;
    assign out_funct3       = out_pl.funct3;
    assign out_funct5       = out_pl.funct5;
    assign out_funct7       = out_pl.funct7;
    assign out_funct12      = out_pl.funct12;
    assign out_imm          = out_pl.imm;
    assign out_imm_fmt      = out_pl.fmt;
    assign out_decode_error = out_pl.error;

endmodule

// File: doc/rv_decode_stage.md
RV_DECODE_STAGE -- requirements
Module: rv_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, register width; legal values 32 and 64; any other value SHALL fail elaboration.
REQ-002 Parameter ENABLE_FP, default 0; 1 makes the floating-point opcodes legal.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 flush  in  1  synchronous discard of all held instructions.
REQ-006 in_valid / in_ready  in / out  1 / 1  upstream valid/ready handshake.
REQ-007 in_inst  in  32  raw instruction word.
REQ-008 in_pc  in  XLEN  instruction address.
REQ-009 out_valid / out_ready  out / in  1 / 1  downstream valid/ready handshake.
REQ-010 out_inst, out_pc  out  32, XLEN  pass-through of the accepted instruction word and address.
REQ-011 out_opcode  out  7  opcode field.
REQ-012 out_rd, out_rs1, out_rs2, out_rs3  out  5 each  register-address fields.
REQ-013 out_funct3, out_funct5, out_funct7, out_funct12  out  3, 5, 7, 12  function fields.
REQ-014 out_imm  out  XLEN  sign-extended immediate.
REQ-015 out_imm_fmt  out  3  immediate format code (R, I, S, B, U, J, R4).
REQ-016 out_decode_error  out  1  illegal-encoding flag.

Function
REQ-017 Transfer occurs on a port when valid and ready are both high in the same cycle.
REQ-018 Decode is combinational on in_inst; results are registered, so an accepted instruction appears at the output 1 cycle after acceptance.
REQ-019 Buffering is a main register plus a 1-entry skid register, giving full throughput with a registered in_ready.
REQ-020 in_ready = !skid_valid.
REQ-021 Skid register loads when main is valid, out_ready is low and a transfer occurs on the input.
REQ-022 When main drains and skid is valid, skid moves to main in the same cycle as the drain.
REQ-023 Output order SHALL equal acceptance order; no instruction is dropped or duplicated.
REQ-024 Field extraction: rd=[11:7], rs1=[19:15], rs2=[24:20], rs3=[31:27], funct3=[14:12], funct5=[31:27], funct7=[31:25], funct12=[31:20].
REQ-025 Format map:
- I: LOAD, OP-IMM, JALR, MISC-MEM, SYSTEM, OP-IMM-32, LOAD-FP
- S: STORE, STORE-FP
- B: BRANCH
- U: LUI, AUIPC
- J: JAL
- R: OP, OP-32, AMO, OP-FP
- R4: MADD, MSUB, NMSUB, NMADD
REQ-026 Immediate: assembled per its format, sign-extended from inst[31] to XLEN; R and R4 formats give 0.
REQ-027 out_decode_error is set when any of the following holds:
- in_inst[1:0] != 2'b11
- opcode is not in the REQ-025 map
- OP-32 or OP-IMM-32 with XLEN=32
- FP opcodes (LOAD-FP, STORE-FP, OP-FP, R4 group) with ENABLE_FP=0
- OP-IMM shift (funct3 001/101) with XLEN=32 and inst[25]=1
REQ-028 An instruction with an error is still forwarded normally; the error is only flagged.
REQ-029 flush: main_valid and skid_valid clear at the next edge.
REQ-030 flush: in_ready forced low during the flush cycle; no input is accepted that cycle.
REQ-031 flush: an output transfer that occurs in the flush cycle still counts as completed.
REQ-032 Simultaneous input and output transfer with skid empty: main is replaced by the new instruction, and the skid register is untouched.

Reset
REQ-033 While rst_n is low: main_valid=0, skid_valid=0, out_valid=0, in_ready=0; all output data registers read 0.
REQ-034 in_ready rises on the first clock edge after rst_n deasserts.
REQ-035 Reset asserted mid-stream discards every held instruction immediately, without waiting for a clock edge.

Structure
REQ-036 Package rv (shared) SHALL hold the opcode constants, the imm-format enum, and the field-width typedefs as XLEN-independent types.
REQ-037 The package SHALL also hold an rv_decode function taking (inst, XLEN, ENABLE_FP) and returning the fields and error.
REQ-038 rv_decode_stage holds only the handshake and registers.
REQ-039 One sub-module, rv_skid_buffer, parametrised on payload width, SHALL implement the main/skid register pair.

Verification
REQ-040 Decode, XLEN=32: 0xFFF00093 (addi x1,x0,-1) -> rd=1, rs1=0, imm=0xFFFFFFFF, fmt=I, error=0, output valid 1 cycle later.
REQ-041 Decode, XLEN=64:
- 0x800002B7 (lui x5,0x80000) -> imm=0xFFFFFFFF80000000, fmt=U
- 0x008000EF (jal x1,8) -> imm=8, fmt=J
REQ-042 Errors:
- 0x0000000B -> error=1
- 0x02009093 with XLEN=32 -> error=1
- 0x02009093 with XLEN=64 -> error=0
- 0x00000000 -> error=1
REQ-043 Backpressure: out_ready held low for 4 cycles while 3 instructions are offered back-to-back:
- exactly 2 accepted, then in_ready=0
- after out_ready rises, all 3 emerge in order on consecutive cycles
REQ-044 Flush with main and skid both full -> out_valid=0 the next cycle; in_ready=1 the cycle after the flush.
REQ-045 rst_n pulsed low asynchronously (not clock-aligned) with 2 instructions held -> out_valid drops immediately and no stale instruction appears after reset.
